// File: rtl/rc5_host_sequencer.sv
// rc5_host_sequencer: loads the RC5 key RAM and runs cipher/decipher jobs on the core,
// holding start until the matching done, then presenting the captured result.
module rc5_host_sequencer #(
    parameter int W        = 16,
    parameter int B        = 16,
    parameter int B_LENGTH = $clog2(B),
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          iKeyByte,
    input  logic                iKeyValid,
    output logic                oKeyReady,
    input  logic                iCmdValid,
    input  logic                iCmdMode,
    input  logic [W-1:0]        iCmdA,
    input  logic [W-1:0]        iCmdB,
    output logic                oCmdReady,
    output logic [7:0]          oKey_sub_i,
    output logic [B_LENGTH-1:0] oKey_address,
    output logic                oWen,
    output logic                oStartCipher,
    output logic                oStartDecipher,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    input  logic                iDoneCipher,
    input  logic                iDoneDecipher,
    input  logic [W-1:0]        iA_res,
    input  logic [W-1:0]        iB_res,
    output logic [W-1:0]        oResA,
    output logic [W-1:0]        oResB,
    output logic                oResValid,
    input  logic                iResReady,
    output logic                oError
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LOAD_KEY = 3'd0, READY = 3'd1, RUN = 3'd2, GAP = 3'd3, RESULT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [B_LENGTH-1:0] cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                loaded_q, loaded_d;
    logic                mode_q, mode_d;
    logic [W-1:0]        a_q, b_q, res_a_q, res_b_q;
    logic [7:0]          key_sub_q;
    logic [B_LENGTH-1:0] key_addr_q;
    logic                wen_q, start_c_q, start_d_q, key_ready_q, cmd_ready_q, res_valid_q, err_q;
    logic                cmd_acc, key_acc, key_last, done_match, tmo_exp;

    // A command in READY takes priority over a simultaneous key byte
    assign cmd_acc    = iCmdValid && cmd_ready_q;
    assign key_acc    = iKeyValid && key_ready_q && !cmd_acc;
    assign key_last   = cnt_q == B_LENGTH'(B - 1);
    assign done_match = (state_q == RUN) && (mode_q ? iDoneDecipher : iDoneCipher);
    assign tmo_exp    = (state_q == RUN) && !done_match && (tmo_q == TW'(TIMEOUT - 1));
    assign mode_d     = cmd_acc ? iCmdMode : mode_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        tmo_d    = tmo_q;
        if (key_acc) begin
            cnt_d    = key_last ? '0 : cnt_q + B_LENGTH'(1);
            loaded_d = key_last;
            state_d  = key_last ? READY : LOAD_KEY;
        end
        case (state_q)
            READY: begin
                tmo_d = '0;
                if (cmd_acc) state_d = RUN;
            end
            RUN: begin
                tmo_d = tmo_q + TW'(1);
                if (done_match) state_d = RESULT;
                else if (tmo_exp) state_d = GAP;
            end
            RESULT:  state_d = iResReady ? GAP : RESULT;
            GAP:     state_d = READY;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_KEY;
            cnt_q       <= '0;
            tmo_q       <= '0;
            loaded_q    <= 1'b0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            key_sub_q   <= '0;
            key_addr_q  <= '0;
            wen_q       <= 1'b0;
            start_c_q   <= 1'b0;
            start_d_q   <= 1'b0;
            key_ready_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            loaded_q    <= loaded_d;
            mode_q      <= mode_d;
            wen_q       <= key_acc;
            err_q       <= tmo_exp;
            start_c_q   <= (state_d == RUN) && !mode_d;
            start_d_q   <= (state_d == RUN) && mode_d;
            key_ready_q <= (state_d == LOAD_KEY) || (state_d == READY);
            cmd_ready_q <= (state_d == READY) && loaded_d;
            res_valid_q <= state_d == RESULT;
            if (key_acc) begin
                key_sub_q  <= iKeyByte;
                key_addr_q <= cnt_q;
            end
            if (cmd_acc) begin
                a_q <= iCmdA;
                b_q <= iCmdB;
            end
            if (done_match) begin
                res_a_q <= iA_res;
                res_b_q <= iB_res;
            end
        end
    end

    assign oKeyReady      = key_ready_q;
    assign oCmdReady      = cmd_ready_q;
    assign oKey_sub_i     = key_sub_q;
    assign oKey_address   = key_addr_q;
    assign oWen           = wen_q;
    assign oStartCipher   = start_c_q;
    assign oStartDecipher = start_d_q;
    assign oA             = a_q;
    assign oB             = b_q;
    assign oResA          = res_a_q;
    assign oResB          = res_b_q;
    assign oResValid      = res_valid_q;
    assign oError         = err_q;
endmodule
